sfx_playback_arbiter: RTL and testbench

- Shares the single sound-effect sample ROM and the Audio_Controller DAC path between NUM_SFX game-event requesters (hit, miss, level-up, gameover).
- Arbitrates requests by fixed priority, with preemption, and sequences ROM addresses for the granted clip at the ROM sample rate.
- Formats each ROM word into 32-bit left/right samples and drives the write handshake toward Audio_Controller.
- When no clip is playing, it streams silence so the DAC FIFO never starves.

---
 rtl/sfx_pkg.sv | 21 ++
 rtl/sfx_priority_encoder.sv | 25 ++
 rtl/sfx_playback_arbiter.sv | 120 ++++++++++++
 tb/tb_sfx_playback_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared state type, default sizes and effect indices for sfx playback
package sfx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      LATCH,
      WAIT_SLOT
   } sfx_state_t;

   localparam int SFX_NUM_SFX  = 4;
   localparam int SFX_ADDR_W   = 14;
   localparam int SFX_SAMPLE_W = 6;
   localparam int SFX_RATE_DIV = 6;

   localparam int SFX_HIT      = 0;
   localparam int SFX_GAMEOVER = 1;
   localparam int SFX_LEVELUP  = 2;
   localparam int SFX_MISS     = 3;

endpackage

// File: rtl/sfx_priority_encoder.sv
// rtl/sfx_priority_encoder.sv - lowest-set-index finder over a request vector
module sfx_priority_encoder
   import sfx_pkg::*;
#(
   parameter int N = SFX_NUM_SFX
) (
   input  logic [N-1:0]         req,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/sfx_playback_arbiter.sv
// rtl/sfx_playback_arbiter.sv - priority/preempting sfx arbiter feeding Audio_Controller
// Optional SFX_VOLUME_EN adds a 2-bit volume input applied as an arithmetic shift at LATCH.
module sfx_playback_arbiter
   import sfx_pkg::*;
#(
   parameter int NUM_SFX  = SFX_NUM_SFX,
   parameter int ADDR_W   = SFX_ADDR_W,
   parameter int SAMPLE_W = SFX_SAMPLE_W,
   parameter int RATE_DIV = SFX_RATE_DIV
) (
   input  logic                        CLOCK_50,
   input  logic                        resetn,
   input  logic [NUM_SFX-1:0]          sfx_req,
   input  logic [NUM_SFX*ADDR_W-1:0]   clip_base,
   input  logic [NUM_SFX*ADDR_W-1:0]   clip_len,
   output logic [ADDR_W-1:0]           rom_addr,
   input  logic [SAMPLE_W-1:0]         rom_q,
   input  logic                        audio_out_allowed,
`ifdef SFX_VOLUME_EN
   input  logic [1:0]                  volume,
`endif
   output logic                        write_audio_out,
   output logic [31:0]                 left_channel_audio_out,
   output logic [31:0]                 right_channel_audio_out,
   output logic                        busy,
   output logic [$clog2(NUM_SFX)-1:0]  active_id,
   output logic [NUM_SFX-1:0]          sfx_done
);

   localparam int RC_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

   sfx_state_t          state, state_n;
   logic [NUM_SFX-1:0]  pend, pend_all, clr_mask;
   logic                grant_valid;
   logic [$clog2(NUM_SFX)-1:0] grant_idx;
   logic [ADDR_W-1:0]   g_base, g_len, cnt, len_r;
   logic [RC_W-1:0]     rate_cnt;
   logic [31:0]         sample, fmt_out;
   logic signed [31:0]  fmt;
   logic                rate_wrap, last, free, preempt_ok, start, drop;

   // Same-cycle requests take part in this cycle's grant.
   assign pend_all = pend | sfx_req;

   sfx_priority_encoder #(.N(NUM_SFX)) u_prio (
      .req   (pend_all),
      .valid (grant_valid),
      .idx   (grant_idx)
   );

   assign g_base = clip_base[grant_idx*ADDR_W +: ADDR_W];
   assign g_len  = clip_len[grant_idx*ADDR_W +: ADDR_W];

   assign fmt = {rom_q, {(32-SAMPLE_W){1'b0}}};
`ifdef SFX_VOLUME_EN
   assign fmt_out = fmt >>> volume;
`else
   assign fmt_out = fmt;
`endif

   always_comb begin
      state_n         = state;
      write_audio_out = resetn && audio_out_allowed && (state == IDLE || state == WAIT_SLOT);
      rate_wrap       = (rate_cnt == RC_W'(RATE_DIV - 1));
      last            = (state == WAIT_SLOT) && write_audio_out && rate_wrap
                        && ((cnt + ADDR_W'(1)) == len_r);
      free            = (state == IDLE) || last;
      // Equal index is a retrigger; a lower index preempts.
      preempt_ok      = (state == WAIT_SLOT) && write_audio_out && (grant_idx <= active_id);
      start           = grant_valid && (g_len != '0) && (free || preempt_ok);
      drop            = grant_valid && (g_len == '0) && (free || preempt_ok);
      clr_mask        = (start || drop) ? (NUM_SFX'(1) << grant_idx) : '0;
      case (state)
         FETCH:     state_n = LATCH;
         LATCH:     state_n = WAIT_SLOT;
         WAIT_SLOT: if (write_audio_out && rate_wrap) state_n = last ? IDLE : FETCH;
         default:   state_n = IDLE;
      endcase
      if (start) state_n = FETCH;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state     <= IDLE;
         pend      <= '0;
         rom_addr  <= '0;
         cnt       <= '0;
         len_r     <= '0;
         rate_cnt  <= '0;
         active_id <= '0;
         sample    <= '0;
         sfx_done  <= '0;
      end else begin
         state    <= state_n;
         pend     <= pend_all & ~clr_mask;
         sfx_done <= last ? (NUM_SFX'(1) << active_id) : '0;
         if (start) begin
            rom_addr  <= g_base;
            cnt       <= '0;
            len_r     <= g_len;
            rate_cnt  <= '0;
            active_id <= grant_idx;
         end else if (state == WAIT_SLOT && write_audio_out) begin
            if (rate_wrap) begin
               rate_cnt <= '0;
               cnt      <= cnt + ADDR_W'(1);
               rom_addr <= rom_addr + ADDR_W'(1);
            end else begin
               rate_cnt <= rate_cnt + RC_W'(1);
            end
         end
         if (state == LATCH) sample <= fmt_out;
      end
   end

   assign left_channel_audio_out  = (state == WAIT_SLOT) ? sample : '0;
   assign right_channel_audio_out = left_channel_audio_out;
   assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_sfx_playback_arbiter.sv
// tb/tb_sfx_playback_arbiter.sv - scoreboard bench for sfx_playback_arbiter against a clip-level model
module tb_sfx_playback_arbiter;
   import sfx_pkg::*;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int RD = 2;

   logic            CLOCK_50 = 1'b0;
   logic            resetn = 1'b0;
   logic [N-1:0]    sfx_req = '0;
   logic [N*AW-1:0] clip_base, clip_len;
   logic [AW-1:0]   rom_addr;
   logic [5:0]      rom_q;
   logic            audio_out_allowed = 1'b0;
   logic            write_audio_out;
   logic [31:0]     left_channel_audio_out, right_channel_audio_out;
   logic            busy;
   logic [1:0]      active_id;
   logic [N-1:0]    sfx_done;

   logic [AW-1:0]   base_a[N], len_a[N], stage_base[N], stage_len[N];

   always #10 CLOCK_50 = ~CLOCK_50;

   always_comb begin
      clip_base = '0;
      clip_len  = '0;
      for (int i = 0; i < N; i++) begin
         clip_base[i*AW +: AW] = base_a[i];
         clip_len[i*AW +: AW]  = len_a[i];
      end
   end

   // ROM content is simply the low six address bits, one-cycle read latency.
   always @(posedge CLOCK_50) rom_q <= rom_addr[5:0];

   sfx_playback_arbiter #(.NUM_SFX(N), .ADDR_W(AW), .SAMPLE_W(6), .RATE_DIV(RD)) dut (
      .CLOCK_50                (CLOCK_50),
      .resetn                  (resetn),
      .sfx_req                 (sfx_req),
      .clip_base               (clip_base),
      .clip_len                (clip_len),
      .rom_addr                (rom_addr),
      .rom_q                   (rom_q),
      .audio_out_allowed       (audio_out_allowed),
`ifdef SFX_VOLUME_EN
      .volume                  (2'b00),
`endif
      .write_audio_out         (write_audio_out),
      .left_channel_audio_out  (left_channel_audio_out),
      .right_channel_audio_out (right_channel_audio_out),
      .busy                    (busy),
      .active_id               (active_id),
      .sfx_done                (sfx_done)
   );

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        busy;
      logic [1:0]  id;
      logic        chk_addr;
      logic [13:0] addr;
   } wr_rec_t;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } done_rec_t;

   wr_rec_t   wq[$];
   done_rec_t dq[$];
   wr_rec_t   mon_r;
   done_rec_t mon_d;
   int        n_checks = 0;
   int        n_err = 0;
   int        cyc = 0;
   int        done_seen[N] = '{0, 0, 0, 0};

   // Reference model: what clip is sounding, which sample, how many repeats,
   // and how many fetch cycles remain before the next write may occur.
   bit          m_play = 0;
   int          m_id = 0, m_idx = 0, m_rep = 0, m_delay = 0, m_len = 0;
   logic [13:0] m_base = '0;
   logic [3:0]  m_pend = '0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_cycle();
      wr_rec_t     r;
      done_rec_t   d;
      logic [3:0]  p;
      logic [13:0] a;
      bit          wr, boundary;
      int          g;
      if (!resetn) begin
         m_play = 0; m_pend = '0; m_id = 0;
         return;
      end
      a  = m_base + 14'(m_idx);
      wr = audio_out_allowed && (!m_play || m_delay == 0);
      if (wr) begin
         r.cyc = cyc; r.busy = m_play; r.id = 2'(m_id);
         r.chk_addr = m_play; r.addr = a;
         r.data = m_play ? {a[5:0], 26'd0} : 32'd0;
         wq.push_back(r);
      end
      p = m_pend | sfx_req;
      boundary = !m_play || wr;
      if (m_play) begin
         if (wr) begin
            m_rep++;
            if (m_rep == RD) begin
               m_rep = 0;
               m_idx++;
               if (m_idx == m_len) begin
                  d.cyc = cyc + 1; d.vec = 4'b0001 << m_id;
                  dq.push_back(d);
                  m_play = 0;
               end else begin
                  m_delay = 2;
               end
            end
         end else if (m_delay > 0) begin
            m_delay--;
         end
      end
      if (boundary && p != 0) begin
         g = 0;
         for (int i = N - 1; i >= 0; i--) if (p[i]) g = i;
         if (!m_play || g <= m_id) begin
            p[g] = 1'b0;
            if (len_a[g] != 0) begin
               m_play = 1; m_id = g; m_idx = 0; m_rep = 0; m_delay = 2;
               m_base = base_a[g]; m_len = int'(len_a[g]);
            end
         end
      end
      m_pend = p;
   endtask

   task automatic step(input logic [3:0] req, input logic allow, input logic rst);
      @(posedge CLOCK_50);
      #1;
      sfx_req = req;
      audio_out_allowed = allow;
      resetn = rst;
      base_a = stage_base;
      len_a = stage_len;
      #1;
      model_cycle();
   endtask

   task automatic check_reset_outputs();
      #1;
      chk("rst_write", write_audio_out, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_left", left_channel_audio_out, 0);
      chk("rst_right", right_channel_audio_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_active_id", active_id, 0);
      chk("rst_done", sfx_done, 0);
   endtask

   always @(negedge CLOCK_50) begin
      if (write_audio_out === 1'b1) begin
         if (wq.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL write_unexpected at cycle %0d: got a write, expected none", cyc);
         end else begin
            mon_r = wq.pop_front();
            chk("write_cycle", cyc, mon_r.cyc);
            chk("left", left_channel_audio_out, mon_r.data);
            chk("right", right_channel_audio_out, mon_r.data);
            chk("busy", busy, mon_r.busy);
            chk("active_id", active_id, mon_r.id);
            if (mon_r.chk_addr) chk("rom_addr", rom_addr, mon_r.addr);
         end
      end
      if (sfx_done !== 4'b0000) begin
         for (int i = 0; i < N; i++) if (sfx_done[i]) done_seen[i]++;
         if (dq.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL done_unexpected at cycle %0d: got %b, expected none", cyc, sfx_done);
         end else begin
            mon_d = dq.pop_front();
            chk("done_cycle", cyc, mon_d.cyc);
            chk("done_vec", sfx_done, mon_d.vec);
         end
      end
   end

   initial begin
      stage_base = '{14'd200, 14'd300, 14'd100, 14'd1000};
      stage_len  = '{14'd4, 14'd3, 14'd3, 14'd50};
      base_a = stage_base;
      len_a  = stage_len;

      repeat (3) step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      check_reset_outputs();

      // Idle silence stream.
      repeat (8) step(4'b0000, 1'b1, 1'b1);

      // Single clip 2: base 100, len 3.
      step(4'b0100, 1'b1, 1'b1);
      repeat (30) step(4'b0000, 1'b1, 1'b1);
      chk("done2_count", done_seen[2], 1);
      chk("idle_after_clip2", busy, 0);

      // Preemption of clip 3 by clip 0 around its tenth sample.
      step(4'b1000, 1'b1, 1'b1);
      repeat (42) step(4'b0000, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      repeat (60) step(4'b0000, 1'b1, 1'b1);
      chk("done3_after_preempt", done_seen[3], 0);
      chk("done0_after_preempt", done_seen[0], 1);
      chk("idle_after_preempt", busy, 0);

      // Deferred request behind clip 1, then simultaneous 1010 in idle.
      stage_len[3] = 14'd5;
      step(4'b0010, 1'b1, 1'b1);
      repeat (3) step(4'b0000, 1'b1, 1'b1);
      step(4'b1000, 1'b1, 1'b1);
      repeat (50) step(4'b0000, 1'b1, 1'b1);
      step(4'b1010, 1'b1, 1'b1);
      repeat (60) step(4'b0000, 1'b1, 1'b1);
      chk("done1_count", done_seen[1], 2);
      chk("done3_count", done_seen[3], 2);

      // Backpressure mid-clip, then a one-cycle reset.
      step(4'b1000, 1'b1, 1'b1);
      repeat (10) step(4'b0000, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(4'b0000, 1'b0, 1'b1);
         chk("bp_no_write", write_audio_out, 0);
         chk("bp_busy", busy, 1);
         chk("bp_rom_addr", rom_addr, m_base + 14'(m_idx));
      end
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      check_reset_outputs();
      repeat (5) step(4'b0000, 1'b1, 1'b1);

      // Zero-length clip is dropped; wrap-around addressing at the top of ROM.
      stage_len[2] = 14'd0;
      step(4'b0100, 1'b1, 1'b1);
      repeat (10) step(4'b0000, 1'b1, 1'b1);
      chk("zero_len_idle", busy, 0);
      stage_base[1] = 14'd16383;
      stage_len[1]  = 14'd2;
      step(4'b0010, 1'b1, 1'b1);
      repeat (20) step(4'b0000, 1'b1, 1'b1);

      // Random traffic, backpressure, config churn and rare resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) begin
            for (int k = 0; k < N; k++) begin
               stage_base[k] = ($urandom_range(0, 1) == 1) ? 14'($urandom)
                                                           : 14'(16380 + $urandom_range(0, 3));
               stage_len[k]  = 14'($urandom_range(0, 5));
            end
         end
         step(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 999) != 0) ? 1'b1 : 1'b0);
      end

      repeat (4) step(4'b0000, 1'b0, 1'b1);
      @(negedge CLOCK_50);
      #1;
      chk("writes_outstanding", wq.size(), 0);
      chk("done_outstanding", dq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
